// File: rtl/seq_array_multiplier.sv
// -----------------------------------------------------------------------------
// seq_array_multiplier
//
// Iterative WIDTH x WIDTH multiplier. Each CALC cycle evaluates one row of an
// array multiplier: an AND-gate row (multiplicand magnitude gated by the
// current multiplier LSB), then a ripple add into the upper half of the
// accumulator, then a right shift. Signed operation works on magnitudes and
// negates the final product when the operand signs differ.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstN       in   asynchronous active-low reset
//   m          in   [WIDTH-1:0]   multiplicand, sampled on accept
//   q          in   [WIDTH-1:0]   multiplier, sampled on accept
//   signedMode in   1 = two's complement operands/product, 0 = unsigned
//   inValid    in   operands valid this cycle
//   inReady    out  ready for operands (IDLE only)
//   p          out  [2*WIDTH-1:0] registered product, held after completion
//   outValid   out  p holds a completed result (DONE)
//   outReady   in   consumer takes p this cycle
//   busy       out  high in CALC and DONE
// -----------------------------------------------------------------------------
module seq_array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 signedMode,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [2*WIDTH-1:0]   p,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 busy
);

    // Row counter width is derived from WIDTH and deliberately not overridable.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_mcand;     // magnitude of multiplicand
    logic [WIDTH-1:0]   r_mplier;    // magnitude of multiplier, shifted each row
    logic               r_neg;       // final product must be negated
    logic [PW:0]        r_acc;       // {carry, accumulator}
    logic [CNT_W-1:0]   r_count;
    logic [PW-1:0]      r_p;

    logic               w_accept;
    logic               w_last_row;
    logic [WIDTH-1:0]   w_m_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic               w_neg;
    logic [WIDTH-1:0]   w_row;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH:0]     w_carry;
    logic [PW:0]        w_acc_next;
    logic [PW-1:0]      w_acc_final;
    logic [PW-1:0]      w_p_next;

    // -------------------------------------------------------------------------
    // Handshake and status outputs
    // -------------------------------------------------------------------------
    assign inReady  = (r_state == S_IDLE);
    assign outValid = (r_state == S_DONE);
    assign busy     = (r_state != S_IDLE);
    assign p        = r_p;

    assign w_accept   = inValid && (r_state == S_IDLE);
    assign w_last_row = (r_state == S_CALC) && (r_count == CNT_W'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // Operand magnitudes. The most negative value maps onto itself, which read
    // as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    // -------------------------------------------------------------------------
    assign w_m_mag = (signedMode && m[WIDTH-1]) ? (~m + WIDTH'(1)) : m;
    assign w_q_mag = (signedMode && q[WIDTH-1]) ? (~q + WIDTH'(1)) : q;
    assign w_neg   = signedMode & (m[WIDTH-1] ^ q[WIDTH-1]);

    // -------------------------------------------------------------------------
    // One array-multiplier row: AND row plus ripple-carry adder into the
    // upper accumulator half. The stored carry bit is always zero at this
    // point (cleared on accept, shifted out each row), so the add is
    // effectively upper + row + 0.
    // -------------------------------------------------------------------------
    assign w_carry[0] = r_acc[PW];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
            logic w_a;
            logic w_b;
            assign w_row[gi]      = r_mcand[gi] & r_mplier[0];
            assign w_a            = r_acc[WIDTH + gi];
            assign w_b            = w_row[gi];
            assign w_sum[gi]      = w_a ^ w_b ^ w_carry[gi];
            assign w_carry[gi+1]  = (w_a & w_b) | (w_a & w_carry[gi]) | (w_b & w_carry[gi]);
        end
    endgenerate

    // {carry, sum, lower} shifted right by one; the vacated carry slot is zero.
    assign w_acc_next  = {1'b0, w_carry[WIDTH], w_sum, r_acc[WIDTH-1:1]};
    assign w_acc_final = w_acc_next[PW-1:0];

    // Negating zero yields zero, so a zero operand with differing signs is safe.
    assign w_p_next = r_neg ? (~w_acc_final + PW'(1)) : w_acc_final;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)   w_state_next = S_CALC;
            S_CALC: if (w_last_row) w_state_next = S_DONE;
            S_DONE: if (outReady)   w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_m_mag;
                        r_mplier <= w_q_mag;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    // p is loaded on the same edge that enters DONE.
                    if (w_last_row) begin
                        r_p <= w_p_next;
                    end
                end
                default: begin
                    // DONE holds everything until the consumer takes p.
                end
            endcase
        end
    end

endmodule

// File: doc/seq_array_multiplier.md
Name: seq_array_multiplier

Overview:
- Parametrised, iterative successor to the fixed 2-bit array-multiplier row cells.
- Computes a WIDTH x WIDTH product by evaluating one partial-product row per clock: AND-gate row, then a ripple add into an accumulator.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses valid/ready handshakes on both the operand side and the product side, so it can sit between pipelined datapath stages.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), row-counter width; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on rising edge
rstN  input  1  asynchronous, active-low reset
m  input  WIDTH  multiplicand; sampled on accept
q  input  WIDTH  multiplier; sampled on accept
signedMode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled on accept
inValid  input  1  operands and signedMode are valid this cycle
inReady  output  1  block can accept operands (high only in IDLE)
p  output  2*WIDTH  product; registered; stable while outValid is high
outValid  output  1  p holds a completed result
outReady  input  1  consumer takes p this cycle
busy  output  1  high in CALC and DONE

Behaviour:
- Reset (rstN low, takes effect immediately regardless of clk):
  - state = IDLE, p = 0, outValid = 0, busy = 0, inReady = 1.
  - Accumulator, counter and latched operands cleared.
  - A reset mid-operation discards that operation; no partial result is ever presented.
- FSM states: IDLE, CALC, DONE. inReady = (state == IDLE); outValid = (state == DONE); busy = (state != IDLE).
- IDLE:
  - Accept on a rising edge with inValid && inReady.
  - Latch mag(m) and mag(q). When signedMode = 1, mag(x) is the two's-complement absolute value, held in WIDTH unsigned bits (-2^(WIDTH-1) maps to 2^(WIDTH-1)). When signedMode = 0, mag(x) = x.
  - Latch negResult = signedMode & (m[WIDTH-1] ^ q[WIDTH-1]).
  - Clear the accumulator (2*WIDTH+1 bits, including carry) and set count = 0. Go to CALC.
- CALC, one row per cycle:
  - row = mag(m) AND replicated multiplier LSB.
  - Upper accumulator half + row + 0 goes through a ripple add; the carry-out is kept.
  - The {carry, acc} register then shifts right by 1, and the multiplier register shifts right by 1.
  - count increments by 1.
  - On the edge where count reaches WIDTH, go to DONE and load p on the same edge: p = negResult ? -finalAcc : finalAcc, truncated to 2*WIDTH bits.
- Latency: accept at edge 0 -> outValid high after edge WIDTH (WIDTH CALC cycles).
- DONE:
  - p and outValid are held indefinitely until outReady = 1 at a rising edge, then go to IDLE. p keeps its value afterwards; only outValid drops.
  - inValid is ignored in CALC and DONE, with no queuing. Operand inputs may change freely after accept.
  - There is no same-cycle DONE->accept bypass. Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic rules:
  - The unsigned product never exceeds 2*WIDTH bits.
  - The largest signed magnitude case, (-2^(W-1))^2 = 2^(2W-2), fits in 2*WIDTH signed bits, so there is no overflow in any mode.
  - Zero operands with negResult = 1 must still yield p = 0 (negating zero gives zero).
- Simultaneous events:
  - outReady without outValid has no effect.
  - inValid held high in DONE is not accepted until the first cycle back in IDLE.

Test Plan:
- WIDTH=4, unsigned: m=13, q=11, inValid pulse -> outValid after exactly 4 cycles, p=8'h8F (143); busy high throughout; inReady low until outReady.
- WIDTH=4, unsigned extremes: m=15, q=15 -> p=8'hE1. Then m=0, q=15 -> p=8'h00.
- WIDTH=4, signed: m=-3 (4'hD), q=5 -> p=8'hF1 (-15). Then m=-8, q=-8 -> p=8'h40 (64). Then m=0, q=-1 -> p=8'h00.
- Backpressure: hold outReady=0 for 10 cycles after outValid -> p and outValid stable; inValid pulses meanwhile are ignored; outReady=1 -> IDLE next edge, outValid=0, inReady=1.
- Reset mid-CALC: assert rstN=0 asynchronously at count=2 -> outputs at reset values immediately. Then a new operation m=7, q=6 (unsigned) -> p=8'h2A with no stale data.
- Back-to-back: inValid and outReady held high with a stream of 3 operand pairs -> exactly 3 results, each WIDTH+2=6 cycles apart, in order.
